// File: rtl/tcb_img_feeder_121.sv
// tcb_img_feeder_121: byte-serial image loader and handshake driver for the
// 121-16-10 TCB MNIST classifier. It gathers N_PIX pixels into img_source,
// fires a one-cycle valid_top, waits for ready_top (or times out), and holds
// the prediction until the consumer takes it.
//
// Handshakes: a pixel moves on any rising edge where pix_valid && pix_ready.
// A result moves on any rising edge where result_valid && result_ready.
// Neither producer may withdraw data once it has raised valid. valid_top and
// ready_top are single-cycle pulses with no backpressure.
module tcb_img_feeder_121 #(
    parameter int N_PIX       = 121,
    parameter int PIX_W       = 8,
    parameter int RES_W       = 32,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   pix_valid,
    input  logic                   pix_first,
    output logic                   pix_ready,
    output logic [N_PIX*PIX_W-1:0] img_source,
    output logic                   valid_top,
    input  logic                   ready_top,
    input  logic [RES_W-1:0]       number,
    output logic [RES_W-1:0]       result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   timeout,
    output logic [15:0]            frames_done,
    output logic [1:0]             dbg_state
);

    localparam int K_W   = $clog2(N_PIX);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FIRE   = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t                   state_q;
    logic [K_W-1:0]           k_q;
    logic [CNT_W-1:0]         wcnt_q;
    logic [N_PIX*PIX_W-1:0]   img_q;
    logic                     valid_top_q;
    logic [RES_W-1:0]         result_q;
    logic                     result_valid_q;
    logic                     timeout_q;
    logic [15:0]              frames_q;

    logic                     pix_xfer;
    logic [K_W-1:0]           wr_idx;

    // Pixel acceptance and write slot; pix_first always targets slot 0.
    always_comb begin
        pix_ready = (state_q == S_LOAD) && !rst;
        pix_xfer  = pix_valid && pix_ready;
        wr_idx    = pix_first ? '0 : k_q;
    end

    // Image register: only the addressed byte lane changes on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            img_q <= '0;
        end else if (pix_xfer) begin
            for (int i = 0; i < N_PIX; i++) begin
                if (wr_idx == K_W'(i)) begin
                    img_q[i*PIX_W +: PIX_W] <= pix_data;
                end
            end
        end
    end

    // Frame sequencer: load, start pulse, wait with timeout, report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_LOAD;
            k_q            <= '0;
            wcnt_q         <= '0;
            valid_top_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            frames_q       <= '0;
        end else begin
            valid_top_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (pix_xfer) begin
                        if (pix_first) begin
                            k_q <= K_W'(1);
                        end else if (k_q == K_LAST) begin
                            k_q         <= '0;
                            valid_top_q <= 1'b1;
                            state_q     <= S_FIRE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    wcnt_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_q + 1'b1;
                    // A real answer beats a simultaneous timeout.
                    if (ready_top) begin
                        result_q       <= number;
                        timeout_q      <= 1'b0;
                        result_valid_q <= 1'b1;
                        state_q        <= S_REPORT;
                    end else if (wcnt_q == CNT_LAST) begin
                        result_q       <= '1;
                        timeout_q      <= 1'b1;
                        result_valid_q <= 1'b1;
                        state_q        <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        frames_q       <= frames_q + 16'd1;
                        result_valid_q <= 1'b0;
                        state_q        <= S_LOAD;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign img_source   = img_q;
    assign valid_top    = valid_top_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout      = timeout_q;
    assign frames_done  = frames_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_tcb_img_feeder_121.sv
// Bench for tcb_img_feeder_121: directed frames, a network response model in
// the driver, and a result scoreboard drained by an independent monitor.
module tb_tcb_img_feeder_121;
  localparam int N_PIX = 121;
  localparam int PIX_W = 8;
  localparam int RES_W = 32;
  localparam int TO    = 40;

  logic                   clk;
  logic                   rst;
  logic [PIX_W-1:0]       pix_data;
  logic                   pix_valid;
  logic                   pix_first;
  logic                   pix_ready;
  logic [N_PIX*PIX_W-1:0] img_source;
  logic                   valid_top;
  logic                   ready_top;
  logic [RES_W-1:0]       number;
  logic [RES_W-1:0]       result;
  logic                   result_valid;
  logic                   result_ready;
  logic                   timeout;
  logic [15:0]            frames_done;
  logic [1:0]             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int vt_seen  = 0;
  int bp_bad   = 0;
  logic [RES_W:0] exp_q[$];

  tcb_img_feeder_121 #(
    .N_PIX(N_PIX), .PIX_W(PIX_W), .RES_W(RES_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_first(pix_first),
    .pix_ready(pix_ready), .img_source(img_source),
    .valid_top(valid_top), .ready_top(ready_top), .number(number),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .timeout(timeout), .frames_done(frames_done), .dbg_state(dbg_state)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  // scoreboard monitor: compares every accepted result against the queue head
  always @(negedge clk) begin
    logic [RES_W:0] e;
    if (!rst && result_valid && result_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got timeout=%0b result=0x%0h, required no result", timeout, result);
      end else begin
        e = exp_q.pop_front();
        if ({timeout, result} !== e) begin
          n_fail++;
          $display("FAIL result: got timeout=%0b result=0x%0h, required timeout=%0b result=0x%0h",
                   timeout, result, e[RES_W], e[RES_W-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one pixel transfer, waiting (bounded) for pix_ready
  task automatic send_pixel(input logic [7:0] d, input logic first);
    int g;
    g = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_first = first;
    while (!pix_ready && g < 200) begin
      step();
      g++;
    end
    if (!pix_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL pix_ready_wait: got 0, required 1");
    end
    step();
    if (valid_top) vt_seen++;
  endtask

  task automatic end_stream();
    pix_valid = 1'b0;
    pix_first = 1'b0;
    pix_data  = '0;
  endtask

  // network model, entered in the FIRE cycle right after the last pixel
  task automatic run_net(input int lat, input logic [31:0] num, input bit to_mode, input bit fire_rt);
    check("vt_count", 64'(vt_seen), 64'd1);
    check("valid_top_fire", 64'(valid_top), 64'd1);
    if (fire_rt) begin
      ready_top = 1'b1;
      number    = 32'h9;
    end
    step();
    ready_top = 1'b0;
    number    = '0;
    check("valid_top_once", 64'(valid_top), 64'd0);
    if (!to_mode) begin
      exp_q.push_back({1'b0, num});
      repeat (lat - 1) step();
      check("rv_before_ready", 64'(result_valid), 64'd0);
      ready_top = 1'b1;
      number    = num;
      step();
      ready_top = 1'b0;
      number    = '0;
      check("rv_after_ready", 64'(result_valid), 64'd1);
    end else begin
      exp_q.push_back({1'b1, 32'hFFFF_FFFF});
      repeat (TO - 1) step();
      check("rv_before_timeout", 64'(result_valid), 64'd0);
      step();
      check("rv_at_timeout", 64'(result_valid), 64'd1);
    end
  endtask

  task automatic take_result();
    int g;
    g = 0;
    result_ready = 1'b1;
    while (!result_valid && g < 200) begin
      step();
      g++;
    end
    if (!result_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_wait: got 0, required 1");
    end
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pix_data = '0; pix_valid = 1'b0; pix_first = 1'b0;
    ready_top = 1'b0; number = '0; result_ready = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_img", 64'(|img_source), 64'd0);
    check("rst_valid_top", 64'(valid_top), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_frames", 64'(frames_done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_pix_ready", 64'(pix_ready), 64'd1);

    // frame 1: bytes 0..120, network answers 7 after 30 cycles
    vt_seen = 0;
    for (int i = 0; i < N_PIX; i++) send_pixel(8'(i), 1'b0);
    end_stream();
    check("f1_img_lo", 64'(img_source[7:0]), 64'h00);
    check("f1_img_hi", 64'(img_source[967:960]), 64'h78);
    run_net(30, 32'd7, 1'b0, 1'b0);
    check("f1_timeout", 64'(timeout), 64'd0);

    // backpressure: 50 stalled cycles with pixels offered
    bp_bad = 0;
    for (int i = 0; i < 50; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'h55;
      step();
      if (result_valid !== 1'b1 || result !== 32'd7 || pix_ready !== 1'b0) bp_bad++;
    end
    end_stream();
    check("bp_stable_cycles_bad", 64'(bp_bad), 64'd0);
    take_result();
    check("f1_frames", 64'(frames_done), 64'd1);
    check("f1_pix_ready_after", 64'(pix_ready), 64'd1);

    // frame 2: must still take a full 121 transfers
    vt_seen = 0;
    for (int i = 0; i < N_PIX; i++) send_pixel(8'(i + 3), 1'b0);
    end_stream();
    check("f2_img_hi", 64'(img_source[967:960]), 64'h7B);
    run_net(5, 32'h1234_5678, 1'b0, 1'b0);
    take_result();
    check("f2_frames", 64'(frames_done), 64'd2);

    // resync: 60 pixels, pix_first 0xAA, 120 more
    vt_seen = 0;
    for (int i = 0; i < 60; i++) send_pixel(8'(i + 1), 1'b0);
    send_pixel(8'hAA, 1'b1);
    for (int i = 0; i < 120; i++) send_pixel(8'(8'h80 + i), 1'b0);
    end_stream();
    check("rs_img_0", 64'(img_source[7:0]), 64'hAA);
    check("rs_img_1", 64'(img_source[15:8]), 64'h80);
    check("rs_img_hi", 64'(img_source[967:960]), 64'hF7);
    run_net(1, 32'd2, 1'b0, 1'b0);
    take_result();

    // timeout: no answer, then a late ready_top while reporting
    vt_seen = 0;
    for (int i = 0; i < N_PIX; i++) send_pixel(8'(i), 1'b0);
    end_stream();
    run_net(0, 32'd0, 1'b1, 1'b0);
    check("to_flag", 64'(timeout), 64'd1);
    ready_top = 1'b1;
    number    = 32'd5;
    step();
    ready_top = 1'b0;
    number    = '0;
    take_result();
    check("to_frames", 64'(frames_done), 64'd4);

    // collision: ready_top in FIRE ignored, ready_top at last count wins
    vt_seen = 0;
    for (int i = 0; i < N_PIX; i++) send_pixel(8'(i), 1'b0);
    end_stream();
    run_net(TO, 32'd3, 1'b0, 1'b1);
    check("col_timeout", 64'(timeout), 64'd0);
    take_result();
    check("col_frames", 64'(frames_done), 64'd5);

    // mid-frame reset after 100 pixels
    vt_seen = 0;
    for (int i = 0; i < 100; i++) send_pixel(8'(i + 1), 1'b0);
    end_stream();
    rst = 1'b1;
    #1;
    check("mr_pix_ready_in_rst", 64'(pix_ready), 64'd0);
    step();
    check("mr_img", 64'(|img_source), 64'd0);
    check("mr_valid_top", 64'(valid_top), 64'd0);
    check("mr_result", 64'(result), 64'd0);
    check("mr_result_valid", 64'(result_valid), 64'd0);
    check("mr_timeout", 64'(timeout), 64'd0);
    check("mr_frames", 64'(frames_done), 64'd0);
    step();
    check("mr_no_vt", 64'(vt_seen), 64'd0);
    rst = 1'b0;
    #1;
    check("mr_pix_ready", 64'(pix_ready), 64'd1);

    // fresh frame after reset
    vt_seen = 0;
    for (int i = 0; i < N_PIX; i++) send_pixel(8'(8'hFF - i), 1'b0);
    end_stream();
    check("fr_img_lo", 64'(img_source[7:0]), 64'hFF);
    check("fr_img_hi", 64'(img_source[967:960]), 64'h87);
    run_net(10, 32'hC, 1'b0, 1'b0);
    take_result();
    check("fr_frames", 64'(frames_done), 64'd1);

    repeat (5) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
